// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared PE datapath widths, types and round/saturate helper
package pe_pkg;
  localparam int ACC_W   = 19;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 6;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] act_t;

  localparam logic [SHIFT_W-1:0]   SH_MAX = SHIFT_W'(ACC_W);
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = -(ACC_W+1)'(2 ** (OUT_W - 1));

  // Arithmetic right shift with round-half-to-even, then clamp to act_t range.
  function automatic act_t round_sat(input acc_t c, input logic [SHIFT_W-1:0] shift);
    logic signed [ACC_W:0] x;
    logic signed [ACC_W:0] q;
    logic [ACC_W:0]        half_bit;
    logic [SHIFT_W-1:0]    sh;
    logic                  half;
    logic                  sticky;
    x        = {c[ACC_W-1], c};
    sh       = (shift > SH_MAX) ? SH_MAX : shift;
    q        = x >>> sh;
    half     = 1'b0;
    sticky   = 1'b0;
    half_bit = '0;
    if (sh != '0) begin
      half_bit = (ACC_W+1)'(1) << (sh - 1'b1);
      half     = |(x & half_bit);
      sticky   = |(x & (half_bit - 1'b1));
    end
    q = q + (ACC_W+1)'(half & (sticky | q[0]));
    if (q > SAT_HI) begin
      q = SAT_HI;
    end else if (q < SAT_LO) begin
      q = SAT_LO;
    end
    return act_t'(q[OUT_W-1:0]);
  endfunction
endpackage

// File: rtl/pe_sync_fifo.sv
// rtl/pe_sync_fifo.sv - power-of-two synchronous FIFO with combinational head read
module pe_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             wr_en, rd_en;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign rd_en   = pop_i & ~empty_o;
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign wr_en   = push_i & (~full_o | rd_en);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/pe_col_requant.sv
// rtl/pe_col_requant.sv - PE column requantize pipe (shift/round/saturate) into a drop-on-full FIFO
module pe_col_requant
  import pe_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [ACC_W-1:0]              in_c,
  input  logic [SHIFT_W-1:0]            in_shift,
  input  logic                          in_propagate,
  input  logic                          in_valid,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    drop_count,
  input  logic                          clr_ovf
);
  logic [ACC_W-1:0]   s1_c_q;
  logic [SHIFT_W-1:0] s1_shift_q;
  logic               s1_prop_q, s1_valid_q;
  act_t               s2_data_q;
  logic               s2_tag_q, s2_valid_q;
  logic               ovf_q, ovf_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               fifo_full, fifo_empty, pop, drop;
  logic [OUT_W:0]     fifo_rdata;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_c_q     <= '0;
      s1_shift_q <= '0;
      s1_prop_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      s1_c_q     <= in_c;
      s1_shift_q <= in_shift;
      s1_prop_q  <= in_propagate;
      s1_valid_q <= in_valid;
      s2_data_q  <= round_sat(acc_t'(s1_c_q), s1_shift_q);
      s2_tag_q   <= s1_prop_q;
      s2_valid_q <= s1_valid_q;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pop  = ~fifo_empty & out_ready;
  assign drop = s2_valid_q & fifo_full & ~pop;

  // A drop on the same edge as clr_ovf takes priority so it is never lost.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d      = 1'b1;
      if (clr_ovf) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  pe_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W + 1)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (RST),
    .push_i  (s2_valid_q),
    .pop_i   (out_ready),
    .wdata_i ({s2_tag_q, s2_data_q}),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_empty ? '0 : fifo_rdata[OUT_W-1:0];
  assign out_tag    = fifo_empty ? 1'b0 : fifo_rdata[OUT_W];
  assign overflow   = ovf_q;
  assign drop_count = drop_cnt_q;
endmodule
